// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared op codes, FSM states and decode helpers for the multiply/divide unit.
package muldiv_unit_pkg;
  typedef enum logic [3:0] {
    MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
  } md_op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} md_state_e;
  function automatic int max_int(input int x, input int y);
    return x > y ? x : y;
  endfunction
  function automatic logic is_mul(input logic [3:0] op);
    return op <= MD_MSUBU;
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
  function automatic logic is_signed_op(input logic [3:0] op);
    return op == MD_MULT || op == MD_MADD || op == MD_MSUB || op == MD_DIV;
  endfunction
endpackage

// File: rtl/md_divider.sv
// md_divider: unsigned restoring divider, one quotient bit per step.
module md_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH:0] sh, diff;
  logic ge;
  always_comb begin
    sh = {rem_q, quo_q[WIDTH-1]};
    diff = sh - {1'b0, dvs_q};
    ge = !diff[WIDTH];
    rem_d = load ? '0 : step ? (ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0]) : rem_q;
    quo_d = load ? dividend : step ? {quo_q[WIDTH-2:0], ge} : quo_q;
    dvs_d = load ? divisor : dvs_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end
  assign quotient = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/accumulate/divide unit with HI/LO registers and flush support.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MULT_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);
  localparam int CW = $clog2(max_int(MULT_CYCLES, WIDTH + 1) + 1);
  md_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [3:0] op_q, op_d;
  logic busy_q, busy_d, done_q, done_d, div0_q, div0_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic issue, a_neg, b_neg, div_load, div_step;
  logic [WIDTH-1:0] a_mag, b_mag, div_quo, div_rem, quo, rem;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod, acc, mul_res;
  md_divider #(.WIDTH(WIDTH)) u_div (
    .clk(clk), .reset(reset), .load(div_load), .step(div_step),
    .dividend(a_mag), .divisor(b_mag), .quotient(div_quo), .remainder(div_rem)
  );
  always_comb begin
    issue = start && !cancel && state_q == S_IDLE;
    a_neg = is_signed_op(op) && a[WIDTH-1];
    b_neg = is_signed_op(op) && b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    // sign-extend signed operands so a single 2W-bit product is exact mod 2^(2W)
    mul_a = {{WIDTH{is_signed_op(op_q) && a_q[WIDTH-1]}}, a_q};
    mul_b = {{WIDTH{is_signed_op(op_q) && b_q[WIDTH-1]}}, b_q};
    prod = mul_a * mul_b;
    acc = {hi_q, lo_q};
    mul_res = (op_q == MD_MADD || op_q == MD_MADDU) ? acc + prod :
              (op_q == MD_MSUB || op_q == MD_MSUBU) ? acc - prod : prod;
    quo = qneg_q ? -div_quo : div_quo;
    rem = rneg_q ? -div_rem : div_rem;
    div_load = issue && is_div(op) && b != '0;
    div_step = state_q == S_DIV;
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    hi_d = hi_q;
    lo_d = lo_q;
    busy_d = busy_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    done_d = 1'b0;
    div0_d = 1'b0;
    if (cancel) begin
      state_d = S_IDLE;
      busy_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (issue) begin
          hi_d = op == MD_MTHI ? a : hi_q;
          lo_d = op == MD_MTLO ? a : lo_q;
          div0_d = is_div(op) && b == '0;
          if (is_mul(op)) begin
            state_d = S_MUL;
            busy_d = 1'b1;
            cnt_d = CW'(MULT_CYCLES - 1);
            a_d = a;
            b_d = b;
            op_d = op;
          end else if (div_load) begin
            state_d = S_DIV;
            busy_d = 1'b1;
            cnt_d = CW'(WIDTH - 1);
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
          end
        end
        S_MUL: if (cnt_q == '0) begin
          {hi_d, lo_d} = mul_res;
          state_d = S_IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else cnt_d = cnt_q - 1'b1;
        S_DIV: if (cnt_q == '0) state_d = S_FIX;
          else cnt_d = cnt_q - 1'b1;
        default: begin
          hi_d = rem;
          lo_d = quo;
          state_d = S_IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
      div0_q <= div0_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
endmodule
